// File: rtl/dmi_boot_sequencer_if.sv
// DMI request/response bundle between the boot sequencer and the debug module.
// Signal suffixes are from the sequencer's point of view.
//   dmi_req_valid_o   : request valid
//   dmi_req_ready_i   : request accepted
//   dmi_req_addr_o    : DMI register address
//   dmi_req_op_o      : 1 = read, 2 = write
//   dmi_req_data_o    : write data
//   dmi_resp_valid_i  : response valid
//   dmi_resp_ready_o  : response accepted
//   dmi_resp_data_i   : read data
//   dmi_resp_status_i : 0 = ok, 2 = failed, 3 = busy
interface dmi_boot_sequencer_if;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i;
  logic [1:0]  dmi_resp_status_i;

  modport master (
    output dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, dmi_resp_ready_o,
    input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_status_i
  );

  modport slave (
    input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o, dmi_resp_ready_o,
    output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_status_i
  );
endinterface

// File: rtl/dmi_boot_sequencer.sv
// DMI master that boots harts under debug control: for each hart selected in
// the mask it halts the hart, writes the boot address into DPC through an
// abstract command, resumes the hart and confirms the resume.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : start pulse, ignored while busy_o
//   boot_addr_i    : DPC value, sampled at start
//   hart_mask_i    : harts to boot, sampled at start
//   dmi            : DMI request/response bundle (master side)
//   busy_o         : sequence running
//   done_o         : one-cycle pulse at the end of a sequence
//   error_o        : sticky error, cleared by the next accepted start
//   err_hart_o     : index of the failing hart
//   err_code_o     : 1 = DMI failed, 2 = poll timeout, 3 = cmderr nonzero
module dmi_boot_sequencer #(
  parameter int unsigned NumHarts    = 1,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned PollTimeout = 4096
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [XLEN-1:0]     boot_addr_i,
  input  logic [NumHarts-1:0] hart_mask_i,
  dmi_boot_sequencer_if.master dmi,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [9:0]          err_hart_o,
  output logic [2:0]          err_code_o
);

  localparam int unsigned CntW    = $clog2(PollTimeout + 1);
  localparam logic [1:0]  OpRead  = 2'd1;
  localparam logic [1:0]  OpWrite = 2'd2;
  localparam logic [2:0]  AarSize = (XLEN == 64) ? 3'd3 : 3'd2;
  // Abstract command: access register, transfer + write, regno = DPC
  localparam logic [31:0] CmdWord = {8'h00, 1'b0, AarSize, 1'b0, 1'b0, 1'b1, 1'b1, 16'h07B1};

  typedef enum logic [3:0] {
    IDLE, ACTIVATE, SEL_HALT, POLL_HALT, WR_DATA0, WR_DATA1, WR_CMD, POLL_CMD,
    CLR_ERR, RESUME, POLL_RESUME, CLR_RESUME, NEXT, FINISH
  } state_e;

  // Each register-access state walks through issue -> request handshake -> response
  typedef enum logic [1:0] {PH_ISSUE, PH_REQ, PH_RESP} phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [NumHarts-1:0] mask_q, mask_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [9:0]          hart_q, hart_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                req_valid_q, req_valid_d;
  logic [6:0]          req_addr_q, req_addr_d;
  logic [1:0]          req_op_q, req_op_d;
  logic [31:0]         req_data_q, req_data_d;
  logic                resp_ready_q, resp_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [9:0]          err_hart_q, err_hart_d;
  logic [2:0]          err_code_q, err_code_d;

  logic [6:0]  acc_addr;
  logic [1:0]  acc_op;
  logic [31:0] acc_data;
  logic [31:0] ctrl_base;
  logic [63:0] addr_ext;
  logic [9:0]  next_hart;
  logic [31:0] rdata;
  logic        poll_again;
  logic        fail;
  logic [2:0]  fail_code;

  assign ctrl_base = {6'b0, hart_q, 15'b0, 1'b1};
  assign addr_ext  = 64'(addr_q);
  assign rdata     = dmi.dmi_resp_data_i;

  // Register address, opcode and data for the access owned by the current state
  always_comb begin
    acc_addr = 7'h00;
    acc_op   = OpWrite;
    acc_data = 32'h0;
    case (state_q)
      ACTIVATE:    begin acc_addr = 7'h10; acc_data = 32'h1; end
      SEL_HALT:    begin acc_addr = 7'h10; acc_data = ctrl_base | 32'h8000_0000; end
      POLL_HALT:   begin acc_addr = 7'h11; acc_op = OpRead; end
      WR_DATA0:    begin acc_addr = 7'h04; acc_data = addr_ext[31:0]; end
      WR_DATA1:    begin acc_addr = 7'h05; acc_data = addr_ext[63:32]; end
      WR_CMD:      begin acc_addr = 7'h17; acc_data = CmdWord; end
      POLL_CMD:    begin acc_addr = 7'h16; acc_op = OpRead; end
      CLR_ERR:     begin acc_addr = 7'h16; acc_data = 32'h700; end
      RESUME:      begin acc_addr = 7'h10; acc_data = ctrl_base | 32'h4000_0000; end
      POLL_RESUME: begin acc_addr = 7'h11; acc_op = OpRead; end
      CLR_RESUME:  begin acc_addr = 7'h10; acc_data = ctrl_base; end
      default:     ;
    endcase
  end

  // Lowest set bit of the remaining mask; visited harts are cleared from it
  always_comb begin
    next_hart = 10'd0;
    for (int i = int'(NumHarts) - 1; i >= 0; i--) begin
      if (mask_q[i]) next_hart = 10'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    hart_d      = hart_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_op_d    = req_op_q;
    req_data_d  = req_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_hart_d  = err_hart_q;
    err_code_d  = err_code_q;
    poll_again  = 1'b0;
    fail        = 1'b0;
    fail_code   = 3'd0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mask_d     = hart_mask_i;
          addr_d     = boot_addr_i;
          hart_d     = 10'd0;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          err_hart_d = 10'd0;
          err_code_d = 3'd0;
          state_d    = ACTIVATE;
        end
      end
      NEXT: begin
        if (mask_q != '0) begin
          hart_d  = next_hart;
          mask_d  = mask_q & (mask_q - NumHarts'(1));
          state_d = SEL_HALT;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        case (phase_q)
          PH_ISSUE: begin
            req_valid_d = 1'b1;
            req_addr_d  = acc_addr;
            req_op_d    = acc_op;
            req_data_d  = acc_data;
            phase_d     = PH_REQ;
          end
          PH_REQ: begin
            if (dmi.dmi_req_ready_i) begin
              req_valid_d = 1'b0;
              phase_d     = PH_RESP;
            end
          end
          PH_RESP: begin
            if (dmi.dmi_resp_valid_i && resp_ready_q) begin
              // busy status replays the held request without touching the poll count
              if (dmi.dmi_resp_status_i == 2'd3) begin
                phase_d = PH_ISSUE;
              end else if (dmi.dmi_resp_status_i != 2'd0) begin
                fail      = 1'b1;
                fail_code = 3'd1;
              end else begin
                case (state_q)
                  ACTIVATE:    state_d = NEXT;
                  SEL_HALT:    state_d = POLL_HALT;
                  POLL_HALT:   if (rdata[9]) state_d = WR_DATA0; else poll_again = 1'b1;
                  WR_DATA0:    state_d = (XLEN == 64) ? WR_DATA1 : WR_CMD;
                  WR_DATA1:    state_d = WR_CMD;
                  WR_CMD:      state_d = POLL_CMD;
                  POLL_CMD: begin
                    if (rdata[12])              poll_again = 1'b1;
                    else if (rdata[10:8] != 0)  state_d = CLR_ERR;
                    else                        state_d = RESUME;
                  end
                  CLR_ERR: begin
                    fail      = 1'b1;
                    fail_code = 3'd3;
                  end
                  RESUME:      state_d = POLL_RESUME;
                  POLL_RESUME: if (rdata[17]) state_d = CLR_RESUME; else poll_again = 1'b1;
                  CLR_RESUME:  state_d = NEXT;
                  default:     ;
                endcase
              end
            end
          end
          default: phase_d = PH_ISSUE;
        endcase
      end
    endcase

    // cnt_q holds the number of unsuccessful reads already made in this poll state
    if (poll_again) begin
      if (cnt_q == CntW'(PollTimeout - 1)) begin
        fail      = 1'b1;
        fail_code = 3'd2;
      end else begin
        cnt_d   = cnt_q + CntW'(1);
        phase_d = PH_ISSUE;
      end
    end

    if (state_d != state_q) begin
      phase_d = PH_ISSUE;
      cnt_d   = '0;
    end

    if (fail) begin
      state_d    = IDLE;
      phase_d    = PH_ISSUE;
      cnt_d      = '0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      error_d    = 1'b1;
      err_hart_d = hart_q;
      err_code_d = fail_code;
    end

    // Idle keeps accepting responses so stale ones left over from a reset drain away
    resp_ready_d = (state_d == IDLE) || (phase_d == PH_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      phase_q      <= PH_ISSUE;
      mask_q       <= '0;
      addr_q       <= '0;
      hart_q       <= '0;
      cnt_q        <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_op_q     <= '0;
      req_data_q   <= '0;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_hart_q   <= '0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      hart_q       <= hart_d;
      cnt_q        <= cnt_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_op_q     <= req_op_d;
      req_data_q   <= req_data_d;
      resp_ready_q <= resp_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_hart_q   <= err_hart_d;
      err_code_q   <= err_code_d;
    end
  end

  assign dmi.dmi_req_valid_o  = req_valid_q;
  assign dmi.dmi_req_addr_o   = req_addr_q;
  assign dmi.dmi_req_op_o     = req_op_q;
  assign dmi.dmi_req_data_o   = req_data_q;
  assign dmi.dmi_resp_ready_o = resp_ready_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign error_o              = error_q;
  assign err_hart_o           = err_hart_q;
  assign err_code_o           = err_code_q;

endmodule

// File: tb/tb_dmi_boot_sequencer.sv
// Bench for dmi_boot_sequencer: a behavioural debug-module responder logs every
// accepted request as {op, addr, data} and answers dmcontrol/dmstatus/abstractcs
// accesses; directed scenarios compare the log and status outputs to
// hand-computed values.
`timescale 1ns/1ps
module tb_dmi_boot_sequencer;
  localparam int NumHarts    = 4;
  localparam int XLEN        = 64;
  localparam int PollTimeout = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [XLEN-1:0]     boot_addr;
  logic [NumHarts-1:0] hart_mask;
  logic                busy;
  logic                done;
  logic                error;
  logic [9:0]          err_hart;
  logic [2:0]          err_code;

  dmi_boot_sequencer_if dmi();

  dmi_boot_sequencer #(
    .NumHarts(NumHarts), .XLEN(XLEN), .PollTimeout(PollTimeout)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .boot_addr_i(boot_addr),
    .hart_mask_i(hart_mask), .dmi(dmi), .busy_o(busy), .done_o(done),
    .error_o(error), .err_hart_o(err_hart), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Responder controls (written by the main sequence) and state (written by the responder)
  int          stall_cycles = 0;
  int          resp_delay   = 0;
  bit          stuck_mode   = 1'b0;
  bit          cmderr_mode  = 1'b0;
  int          busy_target  = -1;
  int          cmd_writes   = 0;
  int          consumed     = 0;
  bit          pend         = 1'b0;
  logic [63:0] req_log [$];

  // Expected access trace for one hart at XLEN=64, boot address 0x80000080
  logic [63:0] exp_single [10] = '{
    64'h0000_0210_0000_0001, 64'h0000_0210_8000_0001, 64'h0000_0111_0000_0000,
    64'h0000_0204_8000_0080, 64'h0000_0205_0000_0000, 64'h0000_0217_0033_07B1,
    64'h0000_0116_0000_0000, 64'h0000_0210_4000_0001, 64'h0000_0111_0000_0000,
    64'h0000_0210_0000_0001
  };

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] pack_req(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    return {22'b0, op, 1'b0, a, (op == 2'd1) ? 32'h0 : d};
  endfunction

  function automatic logic [63:0] log_at(input int idx);
    return (idx < req_log.size()) ? req_log[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // Responder: decides ready/response at each falling edge and applies the
  // handshakes it predicted for the rising edge that just passed
  initial begin
    logic [63:0] cur, held, hs_entry;
    logic [31:0] last_ctrl, rd, pend_data;
    logic [1:0]  st, pend_status;
    bit          hs_pred, cons_pred;
    int          stall_cnt, pend_cnt;
    hs_pred = 0; cons_pred = 0; stall_cnt = 0; pend_cnt = 0;
    last_ctrl = 0; held = 0; hs_entry = 0; pend_data = 0; pend_status = 0;
    dmi.dmi_req_ready_i   = 1'b0;
    dmi.dmi_resp_valid_i  = 1'b0;
    dmi.dmi_resp_data_i   = 32'h0;
    dmi.dmi_resp_status_i = 2'd0;
    forever begin
      @(negedge clk);
      if (hs_pred) begin
        req_log.push_back(hs_entry);
        rd = 32'h0;
        st = 2'd0;
        if (hs_entry[41:40] == 2'd2 && hs_entry[38:32] == 7'h10) last_ctrl = hs_entry[31:0];
        if (hs_entry[41:40] == 2'd2 && hs_entry[38:32] == 7'h17) begin
          cmd_writes++;
          if (cmd_writes == busy_target) st = 2'd3;
        end
        if (hs_entry[41:40] == 2'd1 && hs_entry[38:32] == 7'h11 && !stuck_mode)
          rd = last_ctrl[31] ? 32'h200 : (last_ctrl[30] ? 32'h2_0000 : 32'h0);
        if (hs_entry[41:40] == 2'd1 && hs_entry[38:32] == 7'h16)
          rd = cmderr_mode ? 32'h200 : 32'h0;
        pend        = 1'b1;
        pend_cnt    = resp_delay;
        pend_data   = rd;
        pend_status = st;
      end
      if (cons_pred) begin
        dmi.dmi_resp_valid_i = 1'b0;
        consumed++;
      end
      if (pend && !dmi.dmi_resp_valid_i) begin
        if (pend_cnt == 0) begin
          dmi.dmi_resp_valid_i  = 1'b1;
          dmi.dmi_resp_data_i   = pend_data;
          dmi.dmi_resp_status_i = pend_status;
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (dmi.dmi_req_valid_o === 1'b1) begin
        cur = pack_req(dmi.dmi_req_op_o, dmi.dmi_req_addr_o, dmi.dmi_req_data_o);
        if (stall_cnt == 0) held = cur;
        else checkOutput("req_stable", cur, held);
        dmi.dmi_req_ready_i = (stall_cnt >= stall_cycles);
        stall_cnt++;
      end else begin
        dmi.dmi_req_ready_i = 1'b0;
        stall_cnt = 0;
      end
      hs_pred   = (dmi.dmi_req_valid_o === 1'b1) && dmi.dmi_req_ready_i && !rst;
      hs_entry  = pack_req(dmi.dmi_req_op_o, dmi.dmi_req_addr_o, dmi.dmi_req_data_o);
      cons_pred = dmi.dmi_resp_valid_i && (dmi.dmi_resp_ready_o === 1'b1) && !rst;
    end
  end

  task automatic applyStimulus(input logic [NumHarts-1:0] mask, input logic [XLEN-1:0] addr);
    @(negedge clk);
    start     = 1'b1;
    hart_mask = mask;
    boot_addr = addr;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done !== 1'b1 && cycles < budget);
    checkOutput("done_seen", done, 1);
    checkOutput("busy_low_at_done", busy, 0);
    @(negedge clk);
    checkOutput("done_one_pulse", done, 0);
  endtask

  initial begin
    int base, cyc, bad, n11, n04, cons0, wait_cnt;
    rst = 1'b1; start = 1'b0; hart_mask = '0; boot_addr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {dmi.dmi_req_valid_o, dmi.dmi_resp_ready_o, busy, done, error, err_code, err_hart},
                64'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_resp_ready", dmi.dmi_resp_ready_o, 1);

    // Single hart, zero wait
    $display("[TB] single hart");
    base = req_log.size();
    applyStimulus(4'b0001, 64'h8000_0080);
    checkOutput("busy_rise", busy, 1);
    waitDone(200, cyc);
    checkOutput("single_latency", cyc, 33);
    checkOutput("single_error", error, 0);
    checkOutput("single_len", req_log.size() - base, 10);
    for (int i = 0; i < 10; i++) checkOutput($sformatf("single_req%0d", i), log_at(base + i), exp_single[i]);

    // Empty mask: activate only
    $display("[TB] empty mask");
    base = req_log.size();
    applyStimulus(4'b0000, 64'h8000_0080);
    waitDone(100, cyc);
    checkOutput("empty_latency", cyc, 5);
    checkOutput("empty_len", req_log.size() - base, 1);
    checkOutput("empty_activate", log_at(base), 64'h0000_0210_0000_0001);

    // Mask 0b1010 with delayed responses
    $display("[TB] mask 1010");
    resp_delay = 2;
    base = req_log.size();
    applyStimulus(4'b1010, 64'h8000_0080);
    waitDone(400, cyc);
    checkOutput("mask_len", req_log.size() - base, 19);
    checkOutput("mask_halt_h1", log_at(base + 1), 64'h0000_0210_8001_0001);
    checkOutput("mask_halt_h3", log_at(base + 10), 64'h0000_0210_8003_0001);
    bad = 0;
    for (int i = base + 1; i < req_log.size(); i++)
      if (req_log[i][41:32] == 10'h210 && req_log[i][25:16] != 10'd1 && req_log[i][25:16] != 10'd3) bad++;
    checkOutput("mask_hart_field", bad, 0);
    checkOutput("mask_error", error, 0);
    resp_delay = 0;

    // Backpressure, busy retry on the first command, ignored start while busy
    $display("[TB] backpressure");
    stall_cycles = 5;
    busy_target  = cmd_writes + 1;
    base = req_log.size();
    applyStimulus(4'b0001, 64'h0000_0001_2000_0000);
    repeat (12) @(negedge clk);
    applyStimulus(4'b1111, 64'h0);
    waitDone(800, cyc);
    checkOutput("bp_len", req_log.size() - base, 11);
    checkOutput("bp_data0", log_at(base + 3), 64'h0000_0204_2000_0000);
    checkOutput("bp_data1", log_at(base + 4), 64'h0000_0205_0000_0001);
    checkOutput("bp_cmd", log_at(base + 5), 64'h0000_0217_0033_07B1);
    checkOutput("bp_cmd_retry", log_at(base + 6), 64'h0000_0217_0033_07B1);
    checkOutput("bp_poll_cmd", log_at(base + 7), 64'h0000_0116_0000_0000);
    checkOutput("bp_error", error, 0);
    stall_cycles = 0;
    busy_target  = -1;

    // Poll timeout
    $display("[TB] timeout");
    stuck_mode = 1'b1;
    base = req_log.size();
    applyStimulus(4'b0001, 64'h8000_0080);
    waitDone(300, cyc);
    checkOutput("to_status", {error, err_code, err_hart}, {1'b1, 3'd2, 10'd0});
    checkOutput("to_len", req_log.size() - base, 10);
    n11 = 0; n04 = 0;
    for (int i = base; i < req_log.size(); i++) begin
      if (req_log[i][41:32] == 10'h111) n11++;
      if (req_log[i][41:32] == 10'h204) n04++;
    end
    checkOutput("to_poll_reads", n11, 8);
    checkOutput("to_no_data0", n04, 0);
    stuck_mode = 1'b0;

    // cmderr on hart 2, then a fresh start clears the error
    $display("[TB] cmderr");
    cmderr_mode = 1'b1;
    base = req_log.size();
    applyStimulus(4'b0100, 64'h8000_0080);
    waitDone(300, cyc);
    checkOutput("ce_status", {error, err_code, err_hart}, {1'b1, 3'd3, 10'd2});
    checkOutput("ce_clear_write", log_at(req_log.size() - 1), 64'h0000_0216_0000_0700);
    checkOutput("ce_poll_before", log_at(req_log.size() - 2), 64'h0000_0116_0000_0000);
    cmderr_mode = 1'b0;
    applyStimulus(4'b0001, 64'h8000_0080);
    checkOutput("ce_error_cleared", {busy, error}, 2'b10);
    waitDone(200, cyc);
    checkOutput("ce_rerun_error", error, 0);

    // Reset while a dmstatus poll response is outstanding
    $display("[TB] reset mid-poll");
    stuck_mode = 1'b1;
    resp_delay = 6;
    base = req_log.size();
    applyStimulus(4'b0001, 64'h8000_0080);
    wait_cnt = 0;
    while (req_log.size() < base + 3 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("rst_reached_poll", req_log.size() >= base + 3, 1);
    cons0 = consumed;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_outputs",
                {dmi.dmi_req_valid_o, dmi.dmi_resp_ready_o, busy, done, error, err_code, err_hart},
                64'h0);
    wait_cnt = 0;
    while ((pend || dmi.dmi_resp_valid_i) && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("rst_drained", consumed - cons0, 1);
    checkOutput("rst_no_new_req", req_log.size() - base, 3);
    checkOutput("rst_idle", busy, 0);
    stuck_mode = 1'b0;
    resp_delay = 0;
    base = req_log.size();
    applyStimulus(4'b0001, 64'h8000_0080);
    waitDone(200, cyc);
    checkOutput("rst_rerun_len", req_log.size() - base, 10);
    checkOutput("rst_rerun_error", error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
